// File: rtl/tpu_pkg.sv
// tpu_pkg: shared sequencer state type, default array dimension and drain-length helper
package tpu_pkg;
    typedef enum logic [2:0] {IDLE, CLR, LOAD_A, FEED_B, DRAIN, DONE} seq_state_t;
    localparam int DIM_DEF = 8;
    function automatic int drain_len(input int dim);
        return 2 * dim - 2;
    endfunction
endpackage

// File: rtl/systolic_seq.sv
// systolic_seq: one matrix-multiply pass sequencer (load A rows, feed B rows, skew drain, done pulse)
// ports: clk/rst (sync, active-high); start; a_vld/a_rdy and b_vld/b_rdy host handshakes;
//        mem_wren/mem_arow/mem_en/b_zero drive memA/memB; sa_clr/sa_en drive the array; busy/done status
module systolic_seq
    import tpu_pkg::*;
#(
    parameter int DIM = DIM_DEF,
    localparam int CNT_W = $clog2(3 * DIM),
    localparam int AW = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          a_vld,
    output logic          a_rdy,
    input  logic          b_vld,
    output logic          b_rdy,
    output logic          mem_wren,
    output logic [AW-1:0] mem_arow,
    output logic          mem_en,
    output logic          b_zero,
    output logic          sa_clr,
    output logic          sa_en,
    output logic          busy,
    output logic          done
);
    localparam int DLEN = drain_len(DIM);
    seq_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_a_beat;
    logic             w_b_beat;
    logic             w_last_row;
    assign w_a_beat   = (r_state == LOAD_A) && a_vld;
    assign w_b_beat   = (r_state == FEED_B) && b_vld;
    assign w_last_row = r_cnt == CNT_W'(DIM - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE:   r_state <= start ? CLR : IDLE;
                CLR: begin
                    r_cnt   <= '0;
                    r_state <= LOAD_A;
                end
                LOAD_A: if (w_a_beat) begin
                    r_cnt   <= w_last_row ? '0 : r_cnt + 1'b1;
                    r_state <= w_last_row ? FEED_B : LOAD_A;
                end
                // with DIM==1 there is no skew to drain, so skip straight to DONE
                FEED_B: if (w_b_beat) begin
                    r_cnt   <= w_last_row ? '0 : r_cnt + 1'b1;
                    r_state <= w_last_row ? ((DLEN == 0) ? DONE : DRAIN) : FEED_B;
                end
                DRAIN: begin
                    r_cnt   <= (r_cnt == CNT_W'(DLEN - 1)) ? '0 : r_cnt + 1'b1;
                    r_state <= (r_cnt == CNT_W'(DLEN - 1)) ? DONE : DRAIN;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    // a stalled FEED_B cycle drops mem_en/sa_en so the whole skewed datapath freezes together
    always_comb begin
        a_rdy    = r_state == LOAD_A;
        b_rdy    = r_state == FEED_B;
        mem_wren = w_a_beat;
        mem_arow = w_a_beat ? r_cnt[AW-1:0] : '0;
        b_zero   = r_state == DRAIN;
        mem_en   = w_b_beat || (r_state == DRAIN);
        sa_en    = mem_en;
        sa_clr   = r_state == CLR;
        busy     = r_state != IDLE;
        done     = r_state == DONE;
    end
endmodule
